sequenciador_mensagem_s3: RTL and testbench

Upstream driver of the S3-choice seven-segment interface. Generates the 2-bit glyph index {saida1Contador, saida2Contador} that walks the four-glyph message C, P, 1, 0. Each glyph is held for a programmable dwell time, and the message repeats a set number of times. Started by the machine controller when option S3 is selected; signals completion back to it.

---
 rtl/sequenciador_mensagem_s3_pkg.sv | 20 ++
 rtl/sequenciador_mensagem_s3_temporizador_dwell.sv | 30 +++
 rtl/sequenciador_mensagem_s3.sv | 114 +++++++++++
 tb/tb_sequenciador_mensagem_s3.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/sequenciador_mensagem_s3_pkg.sv
// Shared definitions for the S3 message sequencer: FSM states, glyph indices
// and the board default dwell time.
package sequenciador_mensagem_s3_pkg;

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        EXIBINDO = 2'd1,
        PAUSADO  = 2'd2,
        FIM      = 2'd3
    } estado_t;

    localparam logic [1:0] GLIFO_C    = 2'd0;
    localparam logic [1:0] GLIFO_P    = 2'd1;
    localparam logic [1:0] GLIFO_UM   = 2'd2;
    localparam logic [1:0] GLIFO_ZERO = 2'd3;

    // One second per glyph on the 50 MHz board.
    localparam int unsigned DWELL_CICLOS_PADRAO = 50_000_000;

endpackage

// File: rtl/sequenciador_mensagem_s3_temporizador_dwell.sv
// Dwell timer: counts enabled cycles and raises a one-cycle tick on the last
// cycle of each dwell period, wrapping back to zero on that same edge.
module temporizador_dwell #(
    parameter int unsigned DWELL_CICLOS = 4,
    parameter int unsigned LARGURA      = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic limpar,
    input  logic habilitar,
    output logic tick
);

    localparam logic [LARGURA-1:0] ULTIMO = LARGURA'(DWELL_CICLOS - 1);

    logic [LARGURA-1:0] contagem;

    assign tick = habilitar && (contagem == ULTIMO);

    // NOTE: sequential state is always updated with <= so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset || limpar) begin
            contagem <= '0;
        end else if (habilitar) begin
            contagem <= tick ? '0 : contagem + LARGURA'(1);
        end
    end

endmodule

// File: rtl/sequenciador_mensagem_s3.sv
// Walks the glyph index through C, P, 1, 0 with a programmable dwell per
// glyph, repeating the message REPETICOES times (0 = until cancelled).
module sequenciador_mensagem_s3
    import sequenciador_mensagem_s3_pkg::*;
#(
    parameter int unsigned DWELL_CICLOS  = DWELL_CICLOS_PADRAO,
    parameter int unsigned LARGURA_DWELL = 26,
    parameter int unsigned REPETICOES    = 2,
    parameter int unsigned LARGURA_REP   = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic iniciar,
    input  logic pausar,
    input  logic cancelar,
    output logic saida1Contador,
    output logic saida2Contador,
    output logic exibindo,
    output logic ocupado,
    output logic concluido
);

    localparam bit REP_INFINITA = (REPETICOES == 0);
    localparam logic [LARGURA_REP-1:0] REP_FINAL =
        LARGURA_REP'(REP_INFINITA ? 0 : REPETICOES - 1);

    estado_t                estado, prox_estado;
    logic [1:0]             indice, prox_indice;
    logic [LARGURA_REP-1:0] rep, prox_rep;
    logic                   habilitar_dwell, limpar_dwell, tick_dwell;

    // Paused cycles, the pause-request cycle and the cancel cycle never count.
    assign habilitar_dwell = (estado == EXIBINDO) && !pausar && !cancelar;
    assign limpar_dwell    = cancelar || !(estado inside {EXIBINDO, PAUSADO});

    temporizador_dwell #(
        .DWELL_CICLOS (DWELL_CICLOS),
        .LARGURA      (LARGURA_DWELL)
    ) u_temporizador_dwell (
        .clk       (clk),
        .reset     (reset),
        .limpar    (limpar_dwell),
        .habilitar (habilitar_dwell),
        .tick      (tick_dwell)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            estado <= OCIOSO;
            indice <= GLIFO_C;
            rep    <= '0;
        end else begin
            estado <= prox_estado;
            indice <= prox_indice;
            rep    <= prox_rep;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        prox_estado = estado;
        prox_indice = indice;
        prox_rep    = rep;
        unique case (estado)
            OCIOSO: begin
                prox_indice = GLIFO_C;
                prox_rep    = '0;
                if (iniciar) prox_estado = EXIBINDO;
            end
            EXIBINDO: begin
                if (cancelar) begin
                    prox_estado = OCIOSO;
                    prox_indice = GLIFO_C;
                    prox_rep    = '0;
                end else if (pausar) begin
                    prox_estado = PAUSADO;
                end else if (tick_dwell) begin
                    if (indice != GLIFO_ZERO) begin
                        prox_indice = indice + 2'd1;
                    end else if (!REP_INFINITA && rep == REP_FINAL) begin
                        prox_estado = FIM;
                    end else begin
                        prox_indice = GLIFO_C;
                        // Saturates so an endless run never wraps the count.
                        if (rep != '1) prox_rep = rep + LARGURA_REP'(1);
                    end
                end
            end
            PAUSADO: begin
                if (cancelar) begin
                    prox_estado = OCIOSO;
                    prox_indice = GLIFO_C;
                    prox_rep    = '0;
                end else if (!pausar) begin
                    prox_estado = EXIBINDO;
                end
            end
            FIM: begin
                prox_estado = OCIOSO;
                prox_indice = GLIFO_C;
                prox_rep    = '0;
            end
            default: prox_estado = OCIOSO;
        endcase
    end

    assign saida1Contador = indice[1];
    assign saida2Contador = indice[0];
    assign exibindo       = (estado == EXIBINDO) || (estado == PAUSADO);
    assign ocupado        = (estado != OCIOSO);
    assign concluido      = (estado == FIM);

endmodule

// File: tb/tb_sequenciador_mensagem_s3.sv
// Self-checking bench: per-cycle vector tables with expectations derived from
// the glyph timing, pushed to a scoreboard and popped after each edge.
module tb_sequenciador_mensagem_s3;

    typedef struct packed {
        logic reset;
        logic iniciar;
        logic pausar;
        logic cancelar;
    } ent_t;

    typedef struct packed {
        logic [1:0] indice;
        logic       exib;
        logic       ocup;
        logic       conc;
    } sai_t;

    typedef struct {
        ent_t ent;
        sai_t esp;
    } vetor_t;

    localparam int DWELL = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic iniciar = 1'b0, pausar = 1'b0, cancelar = 1'b0;
    logic iniciar_inf = 1'b0, pausar_inf = 1'b0, cancelar_inf = 1'b0;
    logic s1, s2, exib, ocup, conc;
    logic s1_inf, s2_inf, exib_inf, ocup_inf, conc_inf;

    int n_testes = 0;
    int n_falhas = 0;

    vetor_t tabela[$];
    sai_t   fila[$];

    always #5 clk = ~clk;

    sequenciador_mensagem_s3 #(
        .DWELL_CICLOS  (DWELL),
        .LARGURA_DWELL (3),
        .REPETICOES    (2),
        .LARGURA_REP   (4)
    ) u_dut (
        .clk            (clk),
        .reset          (reset),
        .iniciar        (iniciar),
        .pausar         (pausar),
        .cancelar       (cancelar),
        .saida1Contador (s1),
        .saida2Contador (s2),
        .exibindo       (exib),
        .ocupado        (ocup),
        .concluido      (conc)
    );

    sequenciador_mensagem_s3 #(
        .DWELL_CICLOS  (DWELL),
        .LARGURA_DWELL (3),
        .REPETICOES    (0),
        .LARGURA_REP   (4)
    ) u_dut_inf (
        .clk            (clk),
        .reset          (reset),
        .iniciar        (iniciar_inf),
        .pausar         (pausar_inf),
        .cancelar       (cancelar_inf),
        .saida1Contador (s1_inf),
        .saida2Contador (s2_inf),
        .exibindo       (exib_inf),
        .ocupado        (ocup_inf),
        .concluido      (conc_inf)
    );

    // Expected outputs k cycles into a run (k=0 is the first C cycle).
    function automatic sai_t corrida(input int k, input int reps);
        sai_t s;
        s = '0;
        if (reps == 0 || k < 4 * DWELL * reps) begin
            s.indice = 2'((k / DWELL) % 4);
            s.exib   = 1'b1;
            s.ocup   = 1'b1;
        end else if (k == 4 * DWELL * reps) begin
            s.indice = 2'd3;
            s.ocup   = 1'b1;
            s.conc   = 1'b1;
        end
        return s;
    endfunction

    function automatic void add(input logic r, input logic i, input logic p,
                                input logic c, input sai_t s);
        vetor_t v;
        v.ent = '{reset: r, iniciar: i, pausar: p, cancelar: c};
        v.esp = s;
        tabela.push_back(v);
    endfunction

    task automatic check(input string nome, input int passo,
                         input sai_t got, input sai_t esp);
        n_testes++;
        if (got !== esp) begin
            n_falhas++;
            $display("FAIL %s step %0d: got idx=%0d exib=%b ocup=%b conc=%b, want idx=%0d exib=%b ocup=%b conc=%b",
                     nome, passo, got.indice, got.exib, got.ocup, got.conc,
                     esp.indice, esp.exib, esp.ocup, esp.conc);
        end
    endtask

    // Applies the table to one DUT; the other sees idle control inputs.
    task automatic aplicar(input string nome, input bit sel_inf);
        sai_t got, esp;
        for (int n = 0; n < tabela.size(); n++) begin
            @(negedge clk);
            reset        = tabela[n].ent.reset;
            iniciar      = sel_inf ? 1'b0 : tabela[n].ent.iniciar;
            pausar       = sel_inf ? 1'b0 : tabela[n].ent.pausar;
            cancelar     = sel_inf ? 1'b0 : tabela[n].ent.cancelar;
            iniciar_inf  = sel_inf ? tabela[n].ent.iniciar  : 1'b0;
            pausar_inf   = sel_inf ? tabela[n].ent.pausar   : 1'b0;
            cancelar_inf = sel_inf ? tabela[n].ent.cancelar : 1'b0;
            fila.push_back(tabela[n].esp);
            @(posedge clk);
            #1;
            got = sel_inf ? {s1_inf, s2_inf, exib_inf, ocup_inf, conc_inf}
                          : {s1, s2, exib, ocup, conc};
            esp = fila.pop_front();
            check(nome, n, got, esp);
        end
        tabela.delete();
    endtask

    initial begin
        // Reset, then idle.
        for (int n = 0; n < 2; n++) add(1, 0, 0, 0, '0);
        for (int n = 0; n < 10; n++) add(0, 0, 0, 0, '0);
        aplicar("reset_idle", 1'b0);

        // Two full passes and one concluido pulse.
        add(0, 1, 0, 0, corrida(0, 2));
        for (int k = 1; k <= 33; k++) add(0, 0, 0, 0, corrida(k, 2));
        aplicar("full_run", 1'b0);

        // Pause for 5 cycles from dwell 2 of glyph P.
        add(0, 1, 0, 0, corrida(0, 2));
        for (int k = 1; k <= 39; k++) begin
            int ef;
            ef = (k <= 6) ? k : ((k <= 12) ? 6 : k - 6);
            add(0, 0, (k >= 7 && k <= 11), 0, corrida(ef, 2));
        end
        aplicar("pause", 1'b0);

        // Cancel with pause on glyph 1, then restart three cycles later.
        add(0, 1, 0, 0, corrida(0, 2));
        for (int k = 1; k <= 8; k++) add(0, 0, 0, 0, corrida(k, 2));
        add(0, 0, 1, 1, '0);
        add(0, 0, 0, 0, '0);
        add(0, 0, 0, 0, '0);
        add(0, 1, 0, 0, corrida(0, 2));
        for (int k = 1; k <= 5; k++) add(0, 0, 0, 0, corrida(k, 2));
        add(0, 0, 0, 1, '0);
        aplicar("cancel", 1'b0);

        // iniciar mid-run and during FIM is ignored.
        add(0, 1, 0, 0, corrida(0, 2));
        for (int k = 1; k <= 33; k++)
            add(0, (k == 10 || k == 33), 0, 0, corrida(k, 2));
        add(0, 0, 0, 0, '0);
        aplicar("restart_ignored", 1'b0);

        // Endless variant, then a mid-glyph synchronous reset.
        add(1, 0, 0, 0, '0);
        add(1, 0, 0, 0, '0);
        add(0, 1, 0, 0, corrida(0, 0));
        for (int k = 1; k <= 101; k++) add(0, 0, 0, 0, corrida(k, 0));
        add(1, 0, 0, 0, '0);
        add(0, 0, 0, 0, '0);
        aplicar("endless", 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_testes, n_falhas);
        $finish;
    end

endmodule
